// File: rtl/master_biu_bus.sv
// Master-side bus interface unit: turns one-shot transaction requests into the
// pipelined START/CONT bus protocol seen by the SDRAM slave BIU.
module master_biu_bus #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic [3:0]        req_burst,
  input  logic [DATA_W-1:0] wdata,
  output logic              wdata_pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_last,
  output logic              busy,
  output logic              en,
  output logic [ADDR_W-1:0] Address,
  output logic [8:0]        Control,
  output logic [DATA_W-1:0] DataIn,
  input  logic [DATA_W-1:0] DataOut,
  input  logic              Ready
);

  // Handshakes: a request transfers on the rising edge where req_valid and
  // req_ready are both high; a bus beat (address and/or data phase) completes
  // on the rising edge where Ready is high, and nothing on the bus moves otherwise.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_APH  = 2'd1,
    S_PIPE = 2'd2,
    S_LDPH = 2'd3
  } state_t;

  localparam logic [1:0] ST_START = 2'b00;
  localparam logic [1:0] ST_CONT  = 2'b01;
  localparam logic [1:0] ST_IDLE  = 2'b10;

  state_t      state;
  state_t      next_state;
  logic [6:0]  beat_cnt;
  logic        more_beats;
  logic        addr_accept;
  logic        data_done;
  logic        start_req;
  logic [ADDR_W-1:0] addr_inc;

  // Codes 0..6 give 1..64 beats, 7 is a page (64 beats), 1xxx is a single beat.
  function automatic logic [6:0] burst_len(input logic [3:0] code);
    logic [6:0] len;
    if (code[3])
      len = 7'd1;
    else if (code[2:0] == 3'd7)
      len = 7'd64;
    else
      len = 7'd1 << code[2:0];
    return len;
  endfunction

  // Doubleword steps by 4 because the data bus is one word wide.
  always_comb begin
    addr_inc = '0;
    case (Control[2:1])
      2'b00:   addr_inc[2:0] = 3'd1;
      2'b01:   addr_inc[2:0] = 3'd2;
      default: addr_inc[2:0] = 3'd4;
    endcase
  end

  assign more_beats  = (beat_cnt > 7'd1);
  assign addr_accept = ((state == S_APH) || (state == S_PIPE)) && Ready;
  assign data_done   = ((state == S_PIPE) || (state == S_LDPH)) && Ready;
  assign start_req   = (state == S_IDLE) && req_valid && !reset;

  // State register
  always_ff @(posedge clk) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (req_valid)
          next_state = S_APH;
      end
      S_APH, S_PIPE: begin
        if (Ready)
          next_state = more_beats ? S_PIPE : S_LDPH;
      end
      S_LDPH: begin
        if (Ready)
          next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Output logic; pop is withheld in reset so the source never advances on a lost beat.
  always_comb begin
    req_ready = 1'b0;
    busy      = 1'b0;
    wdata_pop = 1'b0;
    case (state)
      S_IDLE: req_ready = !reset;
      S_APH, S_PIPE: begin
        busy      = 1'b1;
        wdata_pop = addr_accept && Control[0] && !reset;
      end
      S_LDPH: busy = 1'b1;
      default: begin
        req_ready = 1'b0;
        busy      = 1'b0;
      end
    endcase
  end

  // Bus datapath: registered address, control, write data and read capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      Address  <= '0;
      Control  <= {ST_IDLE, 7'b0};
      DataIn   <= '0;
      en       <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      beat_cnt <= '0;
    end else begin
      en       <= 1'b1;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;

      if (start_req) begin
        Address  <= req_addr;
        Control  <= {ST_START, req_burst, req_size, req_write};
        beat_cnt <= burst_len(req_burst);
      end

      // Address phase accepted: write data follows one cycle behind it.
      if (addr_accept) begin
        if (Control[0])
          DataIn <= wdata;
        if (more_beats) begin
          Address       <= Address + addr_inc;
          Control[8:7]  <= ST_CONT;
          beat_cnt      <= beat_cnt - 7'd1;
        end else begin
          Control[8:7]  <= ST_IDLE;
        end
      end

      if (data_done && !Control[0]) begin
        rd_data  <= DataOut;
        rd_valid <= 1'b1;
        rd_last  <= (state == S_LDPH);
      end
    end
  end

endmodule

// File: tb/tb_master_biu_bus.sv
// Directed bench for master_biu_bus: slave model, wdata source and scoreboards
// for address beats, write data and read data.
module tb_master_biu_bus;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_write;
  logic [1:0]  req_size;
  logic [3:0]  req_burst;
  logic [31:0] wdata;
  logic        wdata_pop;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_last;
  logic        busy;
  logic        en;
  logic [31:0] Address;
  logic [8:0]  Control;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        Ready;

  master_biu_bus #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_size(req_size), .req_burst(req_burst),
    .wdata(wdata), .wdata_pop(wdata_pop),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
    .busy(busy), .en(en),
    .Address(Address), .Control(Control), .DataIn(DataIn),
    .DataOut(DataOut), .Ready(Ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [40:0] addr_q[$];   // {Address, Control} per address phase
  logic [31:0] wr_q[$];     // DataIn after each pop
  logic [32:0] rd_q[$];     // {rd_last, rd_data}
  logic [31:0] slave_q[$];  // words the slave returns, in order

  int          pops = 0;
  int          rvals = 0;
  logic [31:0] wstep = 32'd0;
  logic [31:0] last_datain = 32'd0;
  logic        w_pend = 1'b0;
  logic        dp_now = 1'b0;
  logic        s_rst, s_rdy, s_aph, s_pop;
  logic [40:0] ea;
  logic [32:0] er;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_len(input logic [3:0] b);
    if (b[3]) return 1;
    if (b == 4'd7) return 64;
    return 1 << b;
  endfunction

  // Monitor + slave + wdata source: sample at negedge, update just after posedge.
  always begin
    @(negedge clk);
    s_rst = reset;
    s_rdy = Ready;
    s_aph = (Control[8] == 1'b0);
    s_pop = wdata_pop;
    if (s_rst) begin
      w_pend = 1'b0;
    end else begin
      if (w_pend) begin
        check("wr_q_nonempty", wr_q.size() != 0, 1);
        if (wr_q.size() != 0) begin
          last_datain = wr_q.pop_front();
          check("datain", DataIn, last_datain);
        end
      end
      w_pend = wdata_pop;
      if (wdata_pop) pops++;
      if (s_aph && s_rdy) begin
        check("addr_q_nonempty", addr_q.size() != 0, 1);
        if (addr_q.size() != 0) begin
          ea = addr_q.pop_front();
          check("address", Address, ea[40:9]);
          check("control", Control, ea[8:0]);
        end
      end
      if (rd_valid) begin
        rvals++;
        check("rd_q_nonempty", rd_q.size() != 0, 1);
        if (rd_q.size() != 0) begin
          er = rd_q.pop_front();
          check("rd_data", rd_data, er[31:0]);
          check("rd_last", rd_last, er[32]);
        end
      end
      if (rd_last && !rd_valid) check("rd_last_alone", rd_last, 0);
    end
    @(posedge clk);
    #1;
    if (s_rst) begin
      dp_now = 1'b0;
    end else begin
      if (dp_now && s_rdy && slave_q.size() != 0) void'(slave_q.pop_front());
      dp_now = (s_aph && s_rdy) || (dp_now && !s_rdy);
      if (s_pop) wdata = wdata + wstep;
    end
    DataOut = (dp_now && slave_q.size() != 0) ? slave_q[0] : 32'hDEADBEEF;
  end

  // Called at posedge+1 while idle; returns at posedge+1 after the accept edge.
  task automatic issue(input logic [31:0] a, input logic w, input logic [1:0] sz,
                       input logic [3:0] b);
    logic [31:0] inc;
    logic [31:0] ba;
    int n;
    n   = exp_len(b);
    inc = (sz == 2'b00) ? 32'd1 : (sz == 2'b01) ? 32'd2 : 32'd4;
    for (int i = 0; i < n; i++) begin
      ba = a + inc * 32'(i);
      addr_q.push_back({ba, (i == 0) ? 2'b00 : 2'b01, b, sz, w});
    end
    req_addr  = a;
    req_write = w;
    req_size  = sz;
    req_burst = b;
    req_valid = 1'b1;
    @(negedge clk);
    check("req_ready_idle", req_ready, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(tag, busy, 0);
    @(posedge clk);
    #1;
  endtask

  logic [31:0] sa;
  int p0, r0;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_write = 1'b0;
    req_size = '0; req_burst = '0; wdata = '0; DataOut = '0; Ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_address", Address, 0);
    check("rst_control", Control, 9'b10_0000_00_0);
    check("rst_datain", DataIn, 0);
    check("rst_en", en, 0);
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_pop", wdata_pop, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_last", rd_last, 0);
    check("rst_rd_data", rd_data, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("post_rst_en", en, 1);
    check("post_rst_req_ready", req_ready, 1);
    @(posedge clk); #1;

    // Single write to the mode-program address
    wdata = 32'h0303034A; wstep = 32'd1;
    wr_q.push_back(32'h0303034A);
    p0 = pops;
    issue(32'h3FFFFFFF, 1'b1, 2'b10, 4'b0000);
    @(negedge clk);
    check("sw_ctrl_start", Control, 9'b00_0000_10_1);
    check("sw_busy", busy, 1);
    @(negedge clk);
    check("sw_ctrl_idle", Control, 9'b10_0000_10_1);
    check("sw_datain", DataIn, 32'h0303034A);
    @(negedge clk);
    check("sw_busy_clear", busy, 0);
    check("sw_req_ready", req_ready, 1);
    @(posedge clk); #1;
    check("sw_pops", pops - p0, 1);

    // Word burst-4 write
    wdata = 32'h11112222; wstep = 32'd4;
    for (int i = 0; i < 4; i++) wr_q.push_back(32'h11112222 + 32'(4 * i));
    p0 = pops;
    issue(32'h00004AD0, 1'b1, 2'b10, 4'b0010);
    wait_idle("w4_idle");
    check("w4_pops", pops - p0, 4);

    // Byte burst-2 read
    slave_q.push_back(32'h000000AA); slave_q.push_back(32'h000000BB);
    rd_q.push_back({1'b0, 32'h000000AA}); rd_q.push_back({1'b1, 32'h000000BB});
    r0 = rvals;
    issue(32'h00014AD0, 1'b0, 2'b00, 4'b0001);
    wait_idle("r2_idle");
    check("r2_rvals", rvals - r0, 2);

    // Halfword burst-8 read with a three-cycle stall
    for (int i = 0; i < 8; i++) begin
      slave_q.push_back(32'hC0000000 + 32'(i));
      rd_q.push_back({(i == 7), 32'hC0000000 + 32'(i)});
    end
    r0 = rvals;
    issue(32'h00024AD0, 1'b0, 2'b01, 4'b0011);
    repeat (3) begin @(posedge clk); #1; end
    Ready = 1'b0;
    sa = last_datain;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("stall_addr", Address, 32'h00024AD6);
      check("stall_ctrl", Control, 9'b01_0011_01_0);
      check("stall_datain", DataIn, sa);
      check("stall_rd_valid", rd_valid, 0);
    end
    @(posedge clk); #1;
    Ready = 1'b1;
    wait_idle("r8_idle");
    check("r8_rvals", rvals - r0, 8);

    // Reset in the middle of a burst-4 write
    wdata = 32'hA0000000; wstep = 32'd1;
    for (int i = 0; i < 4; i++) wr_q.push_back(32'hA0000000 + 32'(i));
    p0 = pops;
    issue(32'h00005000, 1'b1, 2'b10, 4'b0010);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    addr_q.delete(); wr_q.delete(); slave_q.delete(); rd_q.delete();
    @(negedge clk);
    check("mid_rst_control", Control, 9'b10_0000_00_0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_en", en, 0);
    check("mid_rst_address", Address, 0);
    check("mid_rst_datain", DataIn, 0);
    repeat (3) begin @(posedge clk); #1; end
    check("mid_rst_pops", pops - p0, 2);

    // Normal request after the reset
    wdata = 32'h000055AA; wstep = 32'd1;
    wr_q.push_back(32'h000055AA);
    p0 = pops;
    issue(32'h00000100, 1'b1, 2'b10, 4'b0000);
    wait_idle("after_rst_idle");
    check("after_rst_pops", pops - p0, 1);

    // Reserved burst code is a single beat but keeps its code on the bus
    slave_q.push_back(32'hC0DE0001);
    rd_q.push_back({1'b1, 32'hC0DE0001});
    r0 = rvals;
    issue(32'h00000200, 1'b0, 2'b10, 4'b1010);
    wait_idle("rsv_idle");
    check("rsv_rvals", rvals - r0, 1);

    // Address wrap across 2^32
    wdata = 32'h77770000; wstep = 32'd1;
    wr_q.push_back(32'h77770000); wr_q.push_back(32'h77770001);
    p0 = pops;
    issue(32'hFFFFFFFC, 1'b1, 2'b10, 4'b0001);
    wait_idle("wrap_idle");
    check("wrap_pops", pops - p0, 2);

    repeat (2) begin @(posedge clk); #1; end
    check("addr_q_empty", addr_q.size(), 0);
    check("wr_q_empty", wr_q.size(), 0);
    check("rd_q_empty", rd_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
